// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared front-end pipeline constants and helpers
package pipe_pkg;

  // front-end controller state encoding
  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_FLUSH    = 2'd1;
  localparam logic [1:0] ST_MEM_WAIT = 2'd2;

  // hardwired zero register never creates a dependency
  localparam logic [4:0] REG_ZERO = 5'd0;

  // true when a written register can feed a later reader
  function automatic logic reg_match(input logic [4:0] dst, input logic [4:0] src);
    return (dst != REG_ZERO) && (dst == src);
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational load-use comparator
module hazard_detect
  import pipe_pkg::*;
(
  input  logic       ex_memread,
  input  logic [4:0] ex_rt,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  output logic       load_use
);

  // a load in EX feeds a source of the instruction in ID
  always_comb begin
    load_use = ex_memread &&
               (reg_match(ex_rt, id_rs) || (id_uses_rt && reg_match(ex_rt, id_rt)));
  end

endmodule

// File: rtl/ifid_ctrl.sv
// rtl/ifid_ctrl.sv - IF/ID and PC sequencing controller; optional HAZARD_PERF_EN adds perf counters
module ifid_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rt,
  input  logic             ex_branch_taken,
  input  logic             id_jump,
  input  logic             mem_busy,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             pipe_hold,
  output logic             err_timeout,
`ifdef HAZARD_PERF_EN
  output logic [CNT_W-1:0] perf_stall,
  output logic [CNT_W-1:0] perf_flush,
  output logic [CNT_W-1:0] perf_wait,
`endif
  output logic [1:0]       state
);

  localparam logic [15:0] TIMEOUT_V = 16'(MEM_TIMEOUT);

  logic [1:0]  state_next;
  logic        load_use;
  logic        stall_cycle;
  logic [15:0] wait_cnt;
  logic [15:0] wait_next;

  hazard_detect u_hazard_detect (
    .ex_memread (ex_memread),
    .ex_rt      (ex_rt),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_uses_rt (id_uses_rt),
    .load_use   (load_use)
  );

  // enables and next state; memory freeze outranks branch, jump, then load-use
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_flush  = 1'b0;
    pipe_hold   = 1'b0;
    stall_cycle = 1'b0;
    state_next  = state;
    case (state)
      ST_RUN: begin
        if (mem_busy) begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          pipe_hold  = 1'b1;
          state_next = ST_MEM_WAIT;
        end else if (ex_branch_taken) begin
          idex_flush = 1'b1;
          state_next = ST_FLUSH;
        end else if (id_jump) begin
          state_next = ST_FLUSH;
        end else if (load_use) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_flush  = 1'b1;
          stall_cycle = 1'b1;
        end
      end
      ST_FLUSH: begin
        // ID holds a bubble here, so load-use is not considered
        if (mem_busy) begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          pipe_hold  = 1'b1;
          state_next = ST_MEM_WAIT;
        end else if (ex_branch_taken) begin
          idex_flush = 1'b1;
          state_next = ST_FLUSH;
        end else begin
          state_next = ST_RUN;
        end
      end
      ST_MEM_WAIT: begin
        // freeze holds for the cycle mem_busy drops too; hazards re-evaluate in RUN
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        pipe_hold  = 1'b1;
        if (!mem_busy) state_next = ST_RUN;
      end
      default: begin
        state_next = ST_RUN;
      end
    endcase
  end

  // wait counter: starts at 1 on entry, counts while busy, saturates at the limit
  always_comb begin
    wait_next = 16'd0;
    if (mem_busy) begin
      if (state == ST_MEM_WAIT) begin
        wait_next = (wait_cnt < TIMEOUT_V) ? wait_cnt + 16'd1 : wait_cnt;
      end else begin
        wait_next = 16'd1;
      end
    end
  end

  // state, flush pulse flop, watchdog counter and sticky timeout flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_RUN;
      ifid_flush  <= 1'b0;
      wait_cnt    <= 16'd0;
      err_timeout <= 1'b0;
    end else begin
      state      <= state_next;
      ifid_flush <= (state_next == ST_FLUSH);
      wait_cnt   <= wait_next;
      if (mem_busy && (wait_next == TIMEOUT_V)) err_timeout <= 1'b1;
    end
  end

`ifdef HAZARD_PERF_EN
  // saturating occupancy counters for stall, flush and memory-wait cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall <= '0;
      perf_flush <= '0;
      perf_wait  <= '0;
    end else begin
      if (stall_cycle && !(&perf_stall))        perf_stall <= perf_stall + 1'b1;
      if ((state == ST_FLUSH) && !(&perf_flush)) perf_flush <= perf_flush + 1'b1;
      if ((state == ST_MEM_WAIT) && !(&perf_wait)) perf_wait <= perf_wait + 1'b1;
    end
  end
`else
  logic [31:0] unused_perf;
  assign unused_perf = 32'(CNT_W) ^ {31'd0, stall_cycle};
`endif

endmodule

// File: tb/tb_ifid_ctrl.sv
// tb/tb_ifid_ctrl.sv - directed self-checking bench for ifid_ctrl
module tb_ifid_ctrl;

  logic       clk;
  logic       rst_n;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rt;
  logic       ex_memread;
  logic [4:0] ex_rt;
  logic       ex_branch_taken;
  logic       id_jump;
  logic       mem_busy;
  logic       pc_write;
  logic       ifid_write;
  logic       ifid_flush;
  logic       idex_flush;
  logic       pipe_hold;
  logic       err_timeout;
  logic [1:0] state;
`ifdef HAZARD_PERF_EN
  logic [15:0] perf_stall;
  logic [15:0] perf_flush;
  logic [15:0] perf_wait;
`endif

  int errors = 0;
  int checks = 0;

  ifid_ctrl #(.MEM_TIMEOUT(4), .CNT_W(16)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rt      (id_uses_rt),
    .ex_memread      (ex_memread),
    .ex_rt           (ex_rt),
    .ex_branch_taken (ex_branch_taken),
    .id_jump         (id_jump),
    .mem_busy        (mem_busy),
    .pc_write        (pc_write),
    .ifid_write      (ifid_write),
    .ifid_flush      (ifid_flush),
    .idex_flush      (idex_flush),
    .pipe_hold       (pipe_hold),
    .err_timeout     (err_timeout),
`ifdef HAZARD_PERF_EN
    .perf_stall      (perf_stall),
    .perf_flush      (perf_flush),
    .perf_wait       (perf_wait),
`endif
    .state           (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;
    ex_memread = 1'b0; ex_rt = 5'd0;
    ex_branch_taken = 1'b0; id_jump = 1'b0; mem_busy = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    #1;
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++; if (ifid_flush !== 1'b0) begin errors++; $display("FAIL reset_ifid_flush got=%b exp=0", ifid_flush); end
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err_timeout); end
    tick();
    rst_n = 1'b1;
    tick();
    mem_busy = 1'b1;
    tick();
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL reset_pre_wait_state got=%0d exp=2", state); end
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_async_state got=%0d exp=0", state); end
    checks++; if (ifid_flush !== 1'b0) begin errors++; $display("FAIL reset_async_flush got=%b exp=0", ifid_flush); end
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL reset_async_err got=%b exp=0", err_timeout); end
    idle();
    #1;
    rst_n = 1'b1;
    #1;
    checks++; if (pc_write !== 1'b1) begin errors++; $display("FAIL reset_release_pc_write got=%b exp=1", pc_write); end
    tick();
  endtask

  task automatic test_load_use();
    idle();
    ex_memread = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
    #1;
    checks++; if ({pc_write, ifid_write, idex_flush, pipe_hold} !== 4'b0010) begin errors++; $display("FAIL load_use_rs got=%b exp=0010", {pc_write, ifid_write, idex_flush, pipe_hold}); end
    tick();
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL load_use_state got=%0d exp=0", state); end
    ex_rt = 5'd0; id_rs = 5'd0;
    #1;
    checks++; if ({pc_write, ifid_write, idex_flush} !== 3'b110) begin errors++; $display("FAIL load_use_r0 got=%b exp=110", {pc_write, ifid_write, idex_flush}); end
    ex_rt = 5'd7; id_rt = 5'd7; id_rs = 5'd3; id_uses_rt = 1'b1;
    #1;
    checks++; if ({pc_write, idex_flush} !== 2'b01) begin errors++; $display("FAIL load_use_rt got=%b exp=01", {pc_write, idex_flush}); end
    id_uses_rt = 1'b0;
    #1;
    checks++; if ({pc_write, idex_flush} !== 2'b10) begin errors++; $display("FAIL load_use_rt_unused got=%b exp=10", {pc_write, idex_flush}); end
    ex_memread = 1'b0; id_uses_rt = 1'b1;
    #1;
    checks++; if ({pc_write, idex_flush} !== 2'b10) begin errors++; $display("FAIL load_use_no_load got=%b exp=10", {pc_write, idex_flush}); end
    idle();
    tick();
  endtask

  task automatic test_branch();
    idle();
    ex_branch_taken = 1'b1;
    #1;
    checks++; if ({pc_write, ifid_write, idex_flush, ifid_flush} !== 4'b1110) begin errors++; $display("FAIL branch_comb got=%b exp=1110", {pc_write, ifid_write, idex_flush, ifid_flush}); end
    tick();
    checks++; if ({state, ifid_flush} !== 3'b011) begin errors++; $display("FAIL branch_flush got=%b exp=011", {state, ifid_flush}); end
    ex_branch_taken = 1'b0;
    ex_memread = 1'b1; ex_rt = 5'd9; id_rs = 5'd9;
    #1;
    checks++; if ({pc_write, idex_flush} !== 2'b10) begin errors++; $display("FAIL flush_suppress_load_use got=%b exp=10", {pc_write, idex_flush}); end
    tick();
    idle();
    checks++; if ({state, ifid_flush} !== 3'b000) begin errors++; $display("FAIL branch_flush_fall got=%b exp=000", {state, ifid_flush}); end
    tick();
  endtask

  task automatic test_back_to_back();
    int high;
    idle();
    high = 0;
    ex_branch_taken = 1'b1;
    tick();
    high += int'(ifid_flush);
    tick();
    high += int'(ifid_flush);
    checks++; if (idex_flush !== 1'b1) begin errors++; $display("FAIL b2b_idex_flush got=%b exp=1", idex_flush); end
    ex_branch_taken = 1'b0;
    tick();
    high += int'(ifid_flush);
    checks++; if (high !== 2) begin errors++; $display("FAIL b2b_flush_cycles got=%0d exp=2", high); end
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL b2b_state got=%0d exp=0", state); end
    tick();
  endtask

  task automatic test_jump_load_use();
    idle();
    id_jump = 1'b1; ex_memread = 1'b1; ex_rt = 5'd4; id_rs = 5'd4;
    #1;
    checks++; if ({pc_write, ifid_write, idex_flush} !== 3'b110) begin errors++; $display("FAIL jump_wins_comb got=%b exp=110", {pc_write, ifid_write, idex_flush}); end
    tick();
    idle();
    checks++; if (ifid_flush !== 1'b1) begin errors++; $display("FAIL jump_flush got=%b exp=1", ifid_flush); end
    tick();
    checks++; if (ifid_flush !== 1'b0) begin errors++; $display("FAIL jump_flush_fall got=%b exp=0", ifid_flush); end
    ex_branch_taken = 1'b1;
    tick();
    ex_branch_taken = 1'b0; mem_busy = 1'b1;
    #1;
    checks++; if ({pc_write, pipe_hold, idex_flush} !== 3'b010) begin errors++; $display("FAIL flush_busy_comb got=%b exp=010", {pc_write, pipe_hold, idex_flush}); end
    tick();
    checks++; if ({state, ifid_flush} !== 3'b100) begin errors++; $display("FAIL flush_busy_next got=%b exp=100", {state, ifid_flush}); end
    mem_busy = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_timeout();
    logic [3:0] err_seen;
    logic       pcw_seen;
    do_reset();
    idle();
    mem_busy = 1'b1;
    pcw_seen = 1'b0;
    #1;
    checks++; if ({pc_write, ifid_write, pipe_hold, idex_flush} !== 4'b0010) begin errors++; $display("FAIL busy_comb got=%b exp=0010", {pc_write, ifid_write, pipe_hold, idex_flush}); end
    for (int i = 0; i < 4; i++) begin
      tick();
      err_seen[i] = err_timeout;
      pcw_seen = pcw_seen | pc_write;
    end
    checks++; if (err_seen !== 4'b1000) begin errors++; $display("FAIL timeout_4 got=%b exp=1000", err_seen); end
    tick();
    checks++; if ({state, err_timeout, pc_write} !== 4'b1010) begin errors++; $display("FAIL timeout_freeze got=%b exp=1010", {state, err_timeout, pc_write}); end
    mem_busy = 1'b0;
    #1;
    pcw_seen = pcw_seen | pc_write;
    checks++; if (pcw_seen !== 1'b0) begin errors++; $display("FAIL timeout_pc_write got=%b exp=0", pcw_seen); end
    tick();
    checks++; if ({state, pc_write, err_timeout} !== 4'b0011) begin errors++; $display("FAIL timeout_return got=%b exp=0011", {state, pc_write, err_timeout}); end

    do_reset();
    mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL busy3_no_err got=%b exp=0", err_timeout); end
    mem_busy = 1'b0;
    #1;
    checks++; if ({state, pc_write} !== 3'b100) begin errors++; $display("FAIL busy3_drop_cycle got=%b exp=100", {state, pc_write}); end
    tick();
    checks++; if ({state, pc_write, err_timeout} !== 4'b0010) begin errors++; $display("FAIL busy3_return got=%b exp=0010", {state, pc_write, err_timeout}); end
    ex_branch_taken = 1'b1; mem_busy = 1'b1;
    tick();
    mem_busy = 1'b0;
    tick();
    #1;
    checks++; if ({state, idex_flush} !== 3'b001) begin errors++; $display("FAIL pending_branch got=%b exp=001", {state, idex_flush}); end
    tick();
    checks++; if (ifid_flush !== 1'b1) begin errors++; $display("FAIL pending_branch_flush got=%b exp=1", ifid_flush); end
    idle();
    tick();
  endtask

`ifdef HAZARD_PERF_EN
  task automatic test_perf();
    do_reset();
    idle();
    ex_memread = 1'b1; ex_rt = 5'd2; id_rs = 5'd2;
    tick();
    tick();
    idle();
    id_jump = 1'b1;
    tick();
    idle();
    tick();
    mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    mem_busy = 1'b0;
    tick();
    tick();
    checks++; if (perf_stall !== 16'd2) begin errors++; $display("FAIL perf_stall got=%0d exp=2", perf_stall); end
    checks++; if (perf_flush !== 16'd1) begin errors++; $display("FAIL perf_flush got=%0d exp=1", perf_flush); end
    checks++; if (perf_wait !== 16'd3) begin errors++; $display("FAIL perf_wait got=%0d exp=3", perf_wait); end
  endtask
`endif

  initial begin
    idle();
    rst_n = 1'b0;
    test_reset();
    test_load_use();
    test_branch();
    test_back_to_back();
    test_jump_load_use();
    test_timeout();
`ifdef HAZARD_PERF_EN
    test_perf();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
